// File: rtl/clk_tick_arbiter.sv
// clk_tick_arbiter: programmable tick shared round-robin among requesters.
// Define CLK_TICK_ARB_OVERRUN_CNT_EN to add the saturating overrun_cnt output.
module clk_tick_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PRESCALE_W = 17,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PRESCALE_W-1:0] div_value,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    ack,
  input  logic                  clr_overrun,
  output logic                  tick,
  output logic [NUM_REQ-1:0]    grant,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  busy,
`ifdef CLK_TICK_ARB_OVERRUN_CNT_EN
  output logic                  overrun,
  output logic [7:0]            overrun_cnt
`else
  output logic                  overrun
`endif
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] count_q, count_d;
  logic                  tick_q, tick_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic                  ovr_q, ovr_d;
  logic                  ovr_ev;

  logic [IDX_W:0]        sh;
  logic [IDX_W:0]        off;
  logic [IDX_W:0]        sum;
  logic [2*NUM_REQ-1:0]  rot;
  logic                  found;
  logic [IDX_W-1:0]      win;

  always_comb begin
    tick_d  = 1'b0;
    count_d = count_q - 1'b1;
    if (count_q == '0) begin
      tick_d  = 1'b1;
      count_d = div_value;
    end
  end

  // Rotate so bit 0 is the requester just after the pointer.
  always_comb begin
    sh    = {1'b0, ptr_q} + (IDX_W+1)'(1);
    rot   = {req, req} >> sh;
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = (IDX_W+1)'(k + 1);
      end
    end
    sum = {1'b0, ptr_q} + off;
    if (sum >= (IDX_W+1)'(NUM_REQ)) begin
      win = IDX_W'(sum - (IDX_W+1)'(NUM_REQ));
    end else begin
      win = IDX_W'(sum);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    ovr_ev  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick_q && found) begin
          state_d = GRANT;
          idx_d   = win;
          ptr_d   = win;
        end
      end
      GRANT: begin
        if (ack[idx_q]) begin
          if (tick_q && found) begin
            idx_d = win;
            ptr_d = win;
          end else begin
            state_d = IDLE;
          end
        end else if (tick_q) begin
          ovr_ev = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ovr_d = ovr_ev | (ovr_q & ~clr_overrun);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      tick_q  <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef CLK_TICK_ARB_OVERRUN_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_overrun) begin
      cnt_d = {7'd0, ovr_ev};
    end else if (ovr_ev && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign overrun_cnt = cnt_q;
`endif

  assign tick      = tick_q;
  assign busy      = (state_q == GRANT);
  assign grant_idx = idx_q;
  assign overrun   = ovr_q;
  assign grant     = busy ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q) : '0;

endmodule
